// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Iterative radix-2 restoring divider. It divides a 2N-bit unsigned dividend
//   by an N-bit unsigned divisor and produces one quotient bit per clock,
//   starting with the MSB. Only one operation is in flight at a time.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor valid
//   in_ready     high only while IDLE; the operation is accepted on in_valid&&in_ready
//   dividend     2N-bit unsigned dividend
//   divisor      N-bit unsigned divisor
//   out_valid    result valid; held until out_ready
//   out_ready    consumer accepts the result
//   quotient     2N-bit unsigned quotient (all ones on divide-by-zero)
//   remainder    N-bit unsigned remainder (dividend[N-1:0] on divide-by-zero)
//   div_by_zero  the divisor of this result was zero
module seq_restoring_divider #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [2*N-1:0] dvd_sh;
  logic [N-1:0]   dvs;
  logic [N:0]     rem_r;
  logic [2*N-1:0] quo_sh;
  logic [CW-1:0]  cnt;

  logic [N:0]     r_shift;
  logic           r_ge;
  logic [N:0]     r_next;

  // One restoring step. The partial remainder is N+1 bits wide so that a
  // shifted value of 2^N or more still compares correctly against the divisor.
  always_comb begin
    r_shift = {rem_r[N-1:0], dvd_sh[2*N-1]};
    r_ge    = (r_shift >= {1'b0, dvs});
    r_next  = r_ge ? (r_shift - {1'b0, dvs}) : r_shift;
  end

  assign in_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips CALC and goes straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers. For a normal division, the first DONE
  // cycle copies the finished quotient and remainder into the output registers
  // and raises out_valid. A divide-by-zero loads its result at the accept edge.
  // The output registers keep their values after the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh      <= '0;
      dvs         <= '0;
      rem_r       <= '0;
      quo_sh      <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_sh <= dividend;
            dvs    <= divisor;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              rem_r  <= '0;
              quo_sh <= '0;
              cnt    <= CW'(2 * N - 1);
            end
          end
        end
        CALC: begin
          rem_r  <= r_next;
          quo_sh <= {quo_sh[2*N-2:0], r_ge};
          dvd_sh <= {dvd_sh[2*N-2:0], 1'b0};
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            quotient    <= quo_sh;
            remainder   <= rem_r[N-1:0];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
//   Self-checking bench for seq_restoring_divider (N=16). Expected results are
//   pushed to a scoreboard queue when an operation is accepted. They are popped
//   and compared when the DUT presents out_valid.
module tb_seq_restoring_divider;

  localparam int N = 16;

  typedef struct {
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dz;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  int   errors;
  int   checks;
  exp_t sb[$];

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It uses the simulator's native division and does not
  // repeat the shift/subtract algorithm.
  function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a[N-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = a / {{N{1'b0}}, b};
      e.r  = N'(a % {{N{1'b0}}, b});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drives one operation and waits for the accept edge. Sets ok=0 on timeout.
  // The caller pushes the scoreboard entry.
  task automatic start_op(input logic [2*N-1:0] a, input logic [N-1:0] b, output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen, up to a bound.
  task automatic wait_result(output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
  endtask

  // Accepts the pending result with a one-cycle out_ready pulse.
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: in_ready=%b out_valid=%b q=%h r=%h dz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok, ok2;
    int lat;
    exp_t e;
    sb.push_back(model(32'h000F4240, 16'h0007));
    start_op(32'h000F4240, 16'h0007, ok);
    wait_result(lat, ok2);
    checks++;
    if (!ok || !ok2 || lat !== 33) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d edges (ok=%b/%b), required 33", lat, ok, ok2);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz || quotient !== 32'h00022E09 || remainder !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL basic_result: q=%h r=%h dz=%b, required q=00022e09 r=0001 dz=0",
               quotient, remainder, div_by_zero);
    end
    consume();
  endtask

  task automatic test_max();
    logic [2*N-1:0] av[3] = '{32'hFFFFFFFF, 32'h00000005, 32'h00000000};
    logic [N-1:0]   bv[3] = '{16'hFFFF, 16'h0009, 16'h1234};
    logic [2*N-1:0] qv[3] = '{32'h00010001, 32'h0, 32'h0};
    logic [N-1:0]   rv[3] = '{16'h0000, 16'h0005, 16'h0000};
    bit ok, ok2;
    int lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(av[i], bv[i]));
      start_op(av[i], bv[i], ok);
      wait_result(lat, ok2);
      e = sb.pop_front();
      checks++;
      if (!ok || !ok2 || lat !== 33 || quotient !== qv[i] || remainder !== rv[i] ||
          quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
        errors++;
        $display("[TB] FAIL boundary_%0d: lat=%0d q=%h r=%h dz=%b, required lat=33 q=%h r=%h dz=0",
                 i, lat, quotient, remainder, div_by_zero, qv[i], rv[i]);
      end
      consume();
    end
  endtask

  task automatic test_div_zero();
    bit ok, ok2;
    int lat;
    exp_t e;
    sb.push_back(model(32'h12345678, 16'h0000));
    start_op(32'h12345678, 16'h0000, ok);
    wait_result(lat, ok2);
    checks++;
    if (!ok || !ok2 || lat !== 0) begin
      errors++;
      $display("[TB] FAIL div_zero_latency: got %0d extra edges, required 0", lat);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== 32'hFFFFFFFF || remainder !== 16'h5678 || div_by_zero !== 1'b1 ||
        quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("[TB] FAIL div_zero_result: q=%h r=%h dz=%b, required q=ffffffff r=5678 dz=1",
               quotient, remainder, div_by_zero);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_zero_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    int lat;
    exp_t e;
    logic [2*N-1:0] q0;
    logic [N-1:0]   r0;
    sb.push_back(model(32'h00ABCDEF, 16'h0123));
    start_op(32'h00ABCDEF, 16'h0123, ok);
    repeat (5) begin @(posedge clk); #1; end
    // A stray request in the middle of CALC must be ignored.
    in_valid = 1'b1;
    dividend = 32'hDEADBEEF;
    divisor  = 16'h0000;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL calc_in_ready: got %b, required 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat, ok2);
    checks++;
    if (!ok || !ok2 || lat !== 33 - 6) begin
      errors++;
      $display("[TB] FAIL bp_latency: got %0d edges after stray pulse, required 27", lat);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
      errors++;
      $display("[TB] FAIL bp_result: q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b ready=%b q=%h r=%h, required 1 0 %h %h",
                 i, out_valid, in_ready, quotient, remainder, e.q, e.r);
      end
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== q0 || remainder !== r0) begin
      errors++;
      $display("[TB] FAIL bp_release: valid=%b ready=%b q=%h r=%h, required 0 1 %h %h",
               out_valid, in_ready, quotient, remainder, q0, r0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    int lat;
    exp_t e;
    sb.push_back(model(32'h87654321, 16'h00FF));
    start_op(32'h87654321, 16'h00FF, ok);
    repeat (9) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    void'(sb.pop_front());
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b ready=%b q=%h r=%h dz=%b, required 0 1 0 0 0",
               out_valid, in_ready, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(32'd100, 16'd10));
    start_op(32'd100, 16'd10, ok);
    wait_result(lat, ok2);
    e = sb.pop_front();
    checks++;
    if (!ok || !ok2 || lat !== 33 || quotient !== 32'd10 || remainder !== 16'd0 || quotient !== e.q || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset: lat=%0d q=%0d r=%0d dz=%b, required lat=33 q=10 r=0 dz=0",
               lat, quotient, remainder, div_by_zero);
    end
    consume();
  endtask

  task automatic test_round_trip();
    bit ok, ok2;
    int lat;
    exp_t e;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom_range(1, 65535));
      b = N'($urandom_range(1, 65535));
      p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      e.q  = {{N{1'b0}}, a};
      e.r  = '0;
      e.dz = 1'b0;
      sb.push_back(e);
      start_op(p, b, ok);
      wait_result(lat, ok2);
      e = sb.pop_front();
      checks++;
      if (!ok || !ok2 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("[TB] FAIL round_trip_%0d: P=%h B=%h got q=%h r=%h, required q=%h r=0",
                   i, p, b, quotient, remainder, e.q);
      end
      consume();
    end
  endtask

  task automatic test_random();
    bit ok, ok2;
    int lat;
    exp_t e;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    int bad;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = N'($urandom_range(1, 15));
        1: b = N'($urandom_range(32768, 65535));
        2: b = (i % 20 == 2) ? '0 : N'($urandom);
        default: b = N'($urandom);
      endcase
      sb.push_back(model(a, b));
      start_op(a, b, ok);
      wait_result(lat, ok2);
      e = sb.pop_front();
      checks++;
      if (!ok || !ok2 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("[TB] FAIL random_%0d: %h/%h got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                   i, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      consume();
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_max();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
